// File: rtl/memory_arbiter_if.sv
// Bundles the per-CPU request/response vectors and the RAM-side bus.
// The arbiter uses the slave modport; the environment drives through master.
interface memory_arbiter_if #(
   parameter int CPUS   = 2,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32
);
   logic [CPUS-1:0]             iREN;
   logic [CPUS-1:0][ADDR_W-1:0] iaddr;
   logic [CPUS-1:0]             dREN;
   logic [CPUS-1:0]             dWEN;
   logic [CPUS-1:0][ADDR_W-1:0] daddr;
   logic [CPUS-1:0][WORD_W-1:0] dstore;
   logic [CPUS-1:0]             iwait;
   logic [CPUS-1:0][WORD_W-1:0] iload;
   logic [CPUS-1:0]             dwait;
   logic [CPUS-1:0][WORD_W-1:0] dload;
   logic                        ramREN;
   logic                        ramWEN;
   logic [ADDR_W-1:0]           ramaddr;
   logic [WORD_W-1:0]           ramstore;
   logic [WORD_W-1:0]           ramload;
   logic [1:0]                  ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/memory_arbiter.sv
// Registered round-robin arbiter between CPUS cache ports and one RAM port.
// Instruction and data traffic keep separate round-robin pointers; a
// saturating counter forces an instruction grant after STARVE_LIMIT data
// completions while instruction fetches wait. Withdrawing the granted
// request aborts the access without disturbing pointers or counter.

// Per-CPU response steering: a lane only sees RAM data and a low wait
// when it owns the live grant.
module memory_arbiter_lane #(
   parameter int WORD_W = 32
) (
   input  logic              i_sel_i,
   input  logic              i_sel_d,
   input  logic              i_ready,
   input  logic [WORD_W-1:0] i_ramload,
   output logic              o_iwait,
   output logic [WORD_W-1:0] o_iload,
   output logic              o_dwait,
   output logic [WORD_W-1:0] o_dload
);
   assign o_iwait = ~(i_sel_i & i_ready);
   assign o_dwait = ~(i_sel_d & i_ready);
   assign o_iload = i_sel_i ? i_ramload : '0;
   assign o_dload = i_sel_d ? i_ramload : '0;
endmodule

module memory_arbiter #(
   parameter int CPUS         = 2,
   parameter int WORD_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic             CLK,
   input logic             RST,
   memory_arbiter_if.slave bus
);
   localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t           r_state,      w_state_nx;
   logic [IDX_W-1:0] r_g_idx,      w_g_idx_nx;
   logic             r_g_data,     w_g_data_nx;
   logic [IDX_W-1:0] r_i_ptr,      w_i_ptr_nx;
   logic [IDX_W-1:0] r_d_ptr,      w_d_ptr_nx;
   logic [CNT_W-1:0] r_starve_cnt, w_starve_cnt_nx;

   logic [CPUS-1:0]  w_dreq;
   logic             w_any_i;
   logic             w_any_d;
   logic             w_starved;
   logic             w_ready;
   logic             w_live;
   logic [IDX_W-1:0] w_i_pick;
   logic [IDX_W-1:0] w_d_pick;
   logic [IDX_W-1:0] w_g_inc;

   logic [CPUS-1:0]             w_sel_i;
   logic [CPUS-1:0]             w_sel_d;
   logic [CPUS-1:0]             w_iwait;
   logic [CPUS-1:0]             w_dwait;
   logic [CPUS-1:0][WORD_W-1:0] w_iload;
   logic [CPUS-1:0][WORD_W-1:0] w_dload;

   // First set request at or after ptr, wrapping at CPUS.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [CPUS-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] pick;
      logic             found;
      pick  = '0;
      found = 1'b0;
      for (int off = 0; off < CPUS; off++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(off);
         if (sum >= (IDX_W+1)'(CPUS)) sum = sum - (IDX_W+1)'(CPUS);
         idx = sum[IDX_W-1:0];
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign w_dreq    = bus.dREN | bus.dWEN;
   assign w_any_i   = |bus.iREN;
   assign w_any_d   = |w_dreq;
   assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
   assign w_ready   = (bus.ramstate == RAM_ACCESS);
   assign w_i_pick  = rr_pick(bus.iREN, r_i_ptr);
   assign w_d_pick  = rr_pick(w_dreq, r_d_ptr);
   assign w_g_inc   = (r_g_idx == IDX_W'(CPUS - 1)) ? '0 : r_g_idx + 1'b1;

   // The grant stays live only while its owner keeps the request raised;
   // a dropped request is the abort condition.
   assign w_live = (r_state == ST_GRANT) &&
                   (r_g_data ? w_dreq[r_g_idx] : bus.iREN[r_g_idx]);

   // State and grant registers; reset forces IDLE so RAM enables drop at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_g_idx      <= '0;
         r_g_data     <= 1'b0;
         r_i_ptr      <= '0;
         r_d_ptr      <= '0;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_g_idx      <= w_g_idx_nx;
         r_g_data     <= w_g_data_nx;
         r_i_ptr      <= w_i_ptr_nx;
         r_d_ptr      <= w_d_ptr_nx;
         r_starve_cnt <= w_starve_cnt_nx;
      end
   end

   // Arbitrate in IDLE; in GRANT wait for ACCESS or abort on withdrawal.
   always_comb begin
      w_state_nx      = r_state;
      w_g_idx_nx      = r_g_idx;
      w_g_data_nx     = r_g_data;
      w_i_ptr_nx      = r_i_ptr;
      w_d_ptr_nx      = r_d_ptr;
      w_starve_cnt_nx = r_starve_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_starved && w_any_i) begin
               w_state_nx  = ST_GRANT;
               w_g_data_nx = 1'b0;
               w_g_idx_nx  = w_i_pick;
            end else if (w_any_d) begin
               w_state_nx  = ST_GRANT;
               w_g_data_nx = 1'b1;
               w_g_idx_nx  = w_d_pick;
            end else if (w_any_i) begin
               w_state_nx  = ST_GRANT;
               w_g_data_nx = 1'b0;
               w_g_idx_nx  = w_i_pick;
            end
         end
         ST_GRANT: begin
            if (!w_live) begin
               w_state_nx = ST_IDLE;
            end else if (w_ready) begin
               w_state_nx = ST_IDLE;
               if (r_g_data) begin
                  w_d_ptr_nx = w_g_inc;
                  if (!w_any_i)       w_starve_cnt_nx = '0;
                  else if (!w_starved) w_starve_cnt_nx = r_starve_cnt + 1'b1;
               end else begin
                  w_i_ptr_nx      = w_g_inc;
                  w_starve_cnt_nx = '0;
               end
            end
         end
      endcase
   end

   // RAM side driven purely from the grant registers and the owner's request.
   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      if (w_live) begin
         if (r_g_data) begin
            bus.ramaddr = bus.daddr[r_g_idx];
            if (bus.dWEN[r_g_idx]) begin
               bus.ramWEN   = 1'b1;
               bus.ramstore = bus.dstore[r_g_idx];
            end else begin
               bus.ramREN = 1'b1;
            end
         end else begin
            bus.ramaddr = bus.iaddr[r_g_idx];
            bus.ramREN  = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < CPUS; g++) begin : g_lane
      assign w_sel_i[g] = w_live & ~r_g_data & (r_g_idx == IDX_W'(g));
      assign w_sel_d[g] = w_live &  r_g_data & (r_g_idx == IDX_W'(g));
      memory_arbiter_lane #(.WORD_W(WORD_W)) u_lane (
         .i_sel_i   (w_sel_i[g]),
         .i_sel_d   (w_sel_d[g]),
         .i_ready   (w_ready),
         .i_ramload (bus.ramload),
         .o_iwait   (w_iwait[g]),
         .o_iload   (w_iload[g]),
         .o_dwait   (w_dwait[g]),
         .o_dload   (w_dload[g])
      );
   end

   assign bus.iwait = w_iwait;
   assign bus.dwait = w_dwait;
   assign bus.iload = w_iload;
   assign bus.dload = w_dload;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a vector table, hand sequences for the
// multi-cycle corners (round-robin, starvation, abort, reset mid-grant),
// then random traffic against a transaction-level reference model.
module tb_memory_arbiter;
   localparam int CPUS = 2;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 32;
   localparam int LIM = 4;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;

   memory_arbiter_if #(.CPUS(CPUS), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

   memory_arbiter #(.CPUS(CPUS), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
                    .STARVE_LIMIT(LIM)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic set_fixed();
      bus.iaddr[0] = 32'h40;   bus.iaddr[1] = 32'h44;
      bus.daddr[0] = 32'h100;  bus.daddr[1] = 32'h80;
      bus.dstore[0] = 32'h5555; bus.dstore[1] = 32'h1234;
      bus.ramload = 32'hDEADBEEF;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
      bus.ramstate = ACC;
      set_fixed();
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  iren, dren, dwen, rs;
      logic        ren, wen;
      logic [31:0] addr, store;
      logic [1:0]  iw, dw;
      logic [31:0] il0;
   } vec_t;

   vec_t tbl[13];

   // reference model state (transaction level)
   bit m_busy, m_data;
   int m_k, m_iptr, m_dptr, m_cnt;

   function automatic int pick(input logic [1:0] req, input int ptr);
      for (int o = 0; o < CPUS; o++)
         if (req[(ptr + o) % CPUS]) return (ptr + o) % CPUS;
      return 0;
   endfunction

   initial begin
      int seq[12];
      bit live, anyi, anyd, wr;
      logic        e_ren, e_wen;
      logic [31:0] e_addr, e_store;
      logic [1:0]  e_iw, e_dw;
      logic [1:0][31:0] e_il, e_dl;

      tbl[0]  = '{2'b00, 2'b00, 2'b00, ACC,  1'b0, 1'b0, 32'h0,  32'h0,    2'b11, 2'b11, 32'h0};
      tbl[1]  = '{2'b01, 2'b00, 2'b00, ACC,  1'b0, 1'b0, 32'h0,  32'h0,    2'b11, 2'b11, 32'h0};
      tbl[2]  = '{2'b01, 2'b00, 2'b00, ACC,  1'b1, 1'b0, 32'h40, 32'h0,    2'b10, 2'b11, 32'hDEADBEEF};
      tbl[3]  = '{2'b00, 2'b00, 2'b00, ACC,  1'b0, 1'b0, 32'h0,  32'h0,    2'b11, 2'b11, 32'h0};
      tbl[4]  = '{2'b01, 2'b10, 2'b10, ACC,  1'b0, 1'b0, 32'h0,  32'h0,    2'b11, 2'b11, 32'h0};
      tbl[5]  = '{2'b01, 2'b10, 2'b10, ACC,  1'b0, 1'b1, 32'h80, 32'h1234, 2'b11, 2'b01, 32'h0};
      tbl[6]  = '{2'b11, 2'b00, 2'b00, ACC,  1'b0, 1'b0, 32'h0,  32'h0,    2'b11, 2'b11, 32'h0};
      tbl[7]  = '{2'b11, 2'b00, 2'b00, ACC,  1'b1, 1'b0, 32'h44, 32'h0,    2'b01, 2'b11, 32'h0};
      tbl[8]  = '{2'b11, 2'b00, 2'b00, ACC,  1'b0, 1'b0, 32'h0,  32'h0,    2'b11, 2'b11, 32'h0};
      tbl[9]  = '{2'b11, 2'b00, 2'b00, BUSY, 1'b1, 1'b0, 32'h40, 32'h0,    2'b11, 2'b11, 32'hDEADBEEF};
      tbl[10] = '{2'b11, 2'b00, 2'b00, ERR,  1'b1, 1'b0, 32'h40, 32'h0,    2'b11, 2'b11, 32'hDEADBEEF};
      tbl[11] = '{2'b11, 2'b00, 2'b00, ACC,  1'b1, 1'b0, 32'h40, 32'h0,    2'b10, 2'b11, 32'hDEADBEEF};
      tbl[12] = '{2'b00, 2'b00, 2'b00, ACC,  1'b0, 1'b0, 32'h0,  32'h0,    2'b11, 2'b11, 32'h0};

      // ---- vector table from reset ----
      do_reset();
      for (int i = 0; i < 13; i++) begin
         bus.iREN = tbl[i].iren; bus.dREN = tbl[i].dren;
         bus.dWEN = tbl[i].dwen; bus.ramstate = tbl[i].rs;
         #1;
         chk($sformatf("tbl%0d.ramREN", i), bus.ramREN, tbl[i].ren);
         chk($sformatf("tbl%0d.ramWEN", i), bus.ramWEN, tbl[i].wen);
         chk($sformatf("tbl%0d.ramaddr", i), bus.ramaddr, tbl[i].addr);
         if (!tbl[i].ren) chk($sformatf("tbl%0d.ramstore", i), bus.ramstore, tbl[i].store);
         chk($sformatf("tbl%0d.iwait", i), bus.iwait, tbl[i].iw);
         chk($sformatf("tbl%0d.dwait", i), bus.dwait, tbl[i].dw);
         chk($sformatf("tbl%0d.iload0", i), bus.iload[0], tbl[i].il0);
         @(negedge CLK);
      end

      // ---- round-robin: both iREN held, grant every other cycle ----
      do_reset();
      bus.iREN = 2'b11;
      seq = '{3, 2, 3, 1, 3, 2, 3, 1, 3, 2, 3, 1};
      for (int c = 0; c < 8; c++) begin
         #1;
         chk($sformatf("rr.c%0d.iwait", c), bus.iwait, seq[c][1:0]);
         @(negedge CLK);
      end

      // ---- starvation guard: 4 data completions then CPU1 fetch ----
      do_reset();
      bus.dREN = 2'b01; bus.iREN = 2'b10;
      seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1};
      for (int c = 0; c < 12; c++) begin
         #1;
         chk($sformatf("starve.c%0d.dwait", c), bus.dwait, (seq[c] == 1) ? 2'b10 : 2'b11);
         chk($sformatf("starve.c%0d.iwait", c), bus.iwait, (seq[c] == 2) ? 2'b01 : 2'b11);
         @(negedge CLK);
      end

      // ---- abort: BUSY for 3 cycles, then dREN[0] withdrawn ----
      do_reset();
      bus.dREN = 2'b01; bus.ramstate = BUSY;
      #1; chk("abort.c0.ramREN", bus.ramREN, 1'b0);
      @(negedge CLK);
      for (int c = 1; c < 4; c++) begin
         #1;
         chk($sformatf("abort.c%0d.ramREN", c), bus.ramREN, 1'b1);
         chk($sformatf("abort.c%0d.dwait", c), bus.dwait, 2'b11);
         @(negedge CLK);
      end
      bus.dREN = 2'b00;
      #1;
      chk("abort.drop.en", {bus.ramREN, bus.ramWEN}, 2'b00);
      chk("abort.drop.waits", {bus.iwait, bus.dwait}, 4'b1111);
      @(negedge CLK);
      bus.dREN = 2'b11; bus.ramstate = ACC;
      #1; chk("abort.idle.ramREN", bus.ramREN, 1'b0);
      @(negedge CLK);
      #1;
      chk("abort.dptr0.dwait", bus.dwait, 2'b10);
      chk("abort.dptr0.ramaddr", bus.ramaddr, 32'h100);
      @(negedge CLK);

      // ---- reset mid-grant; i_ptr first advanced to 1 ----
      bus.dREN = 2'b00; bus.iREN = 2'b01;
      @(negedge CLK);
      #1; chk("rst.fetch0.iwait", bus.iwait, 2'b10);
      @(negedge CLK);
      bus.iREN = 2'b00; bus.dREN = 2'b01; bus.ramstate = BUSY;
      @(negedge CLK);
      #1; chk("rst.pre.ramREN", bus.ramREN, 1'b1);
      #1; RST = 1'b1;
      #1;
      chk("rst.mid.en", {bus.ramREN, bus.ramWEN}, 2'b00);
      chk("rst.mid.waits", {bus.iwait, bus.dwait}, 4'b1111);
      chk("rst.mid.ramaddr", bus.ramaddr, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      bus.dREN = 2'b00; bus.iREN = 2'b11; bus.ramstate = ACC;
      #1; chk("rst.post.idle", bus.ramREN, 1'b0);
      @(negedge CLK);
      #1;
      chk("rst.post.iwait", bus.iwait, 2'b10);
      chk("rst.post.ramaddr", bus.ramaddr, 32'h40);
      @(negedge CLK);

      // ---- random traffic against the reference model ----
      do_reset();
      m_busy = 0; m_data = 0; m_k = 0; m_iptr = 0; m_dptr = 0; m_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 9) < 3) begin
            bus.iREN = 2'($urandom); bus.dREN = 2'($urandom); bus.dWEN = 2'($urandom);
            bus.iaddr[0] = $urandom; bus.iaddr[1] = $urandom;
            bus.daddr[0] = $urandom; bus.daddr[1] = $urandom;
            bus.dstore[0] = $urandom; bus.dstore[1] = $urandom;
         end
         bus.ramstate = ($urandom_range(0, 1) == 1) ? ACC : 2'($urandom_range(0, 3));
         bus.ramload  = $urandom;
         #1;
         anyi = |bus.iREN;
         anyd = |(bus.dREN | bus.dWEN);
         live = m_busy && (m_data ? (bus.dREN[m_k] | bus.dWEN[m_k]) : bus.iREN[m_k]);
         wr   = live && m_data && bus.dWEN[m_k];
         e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
         e_iw = 2'b11; e_dw = 2'b11; e_il = '0; e_dl = '0;
         if (live) begin
            if (m_data) begin
               e_addr = bus.daddr[m_k];
               if (wr) begin e_wen = 1; e_store = bus.dstore[m_k]; end
               else e_ren = 1;
               e_dl[m_k] = bus.ramload;
               e_dw[m_k] = (bus.ramstate != ACC);
            end else begin
               e_addr = bus.iaddr[m_k];
               e_ren = 1;
               e_il[m_k] = bus.ramload;
               e_iw[m_k] = (bus.ramstate != ACC);
            end
         end
         chk($sformatf("rnd%0d.en", c), {bus.ramREN, bus.ramWEN}, {e_ren, e_wen});
         chk($sformatf("rnd%0d.waits", c), {bus.iwait, bus.dwait}, {e_iw, e_dw});
         if (!m_busy || live) begin
            chk($sformatf("rnd%0d.ramaddr", c), bus.ramaddr, e_addr);
            chk($sformatf("rnd%0d.iload", c), bus.iload, e_il);
            chk($sformatf("rnd%0d.dload", c), bus.dload, e_dl);
            if (!live || wr) chk($sformatf("rnd%0d.ramstore", c), bus.ramstore, e_store);
         end
         // effect of the coming clock edge
         if (!m_busy) begin
            if (m_cnt == LIM && anyi) begin
               m_busy = 1; m_data = 0; m_k = pick(bus.iREN, m_iptr);
            end else if (anyd) begin
               m_busy = 1; m_data = 1; m_k = pick(bus.dREN | bus.dWEN, m_dptr);
            end else if (anyi) begin
               m_busy = 1; m_data = 0; m_k = pick(bus.iREN, m_iptr);
            end
         end else if (!live) begin
            m_busy = 0;
         end else if (bus.ramstate == ACC) begin
            m_busy = 0;
            if (m_data) begin
               m_dptr = (m_k + 1) % CPUS;
               m_cnt = anyi ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
            end else begin
               m_iptr = (m_k + 1) % CPUS;
               m_cnt = 0;
            end
         end
         @(negedge CLK);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Parametrised RAM arbiter for the multicore datapath. It sits between `CPUS` cache/datapath ports and the single-ported RAM model. It replaces the fixed two-port combinational instruction/data mux with a registered grant FSM, and adds:
- independent round-robin pointers for instruction and data traffic;
- an instruction-starvation guard;
- clean abort when a requester withdraws.

## Interface
Parameters:
- `CPUS`, 2: number of requesting cores (≥1).
- `WORD_W`, 32: data word width.
- `ADDR_W`, 32: RAM address width.
- `STARVE_LIMIT`, 4: consecutive completed data grants tolerated while any `iREN` is pending; when reached, the next grant goes to instruction traffic.

Ports (per-CPU vectors are packed, CPU i at slice i):
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `iREN` in CPUS: instruction read request.
- `iaddr` in CPUS×ADDR_W: instruction address.
- `dREN` in CPUS: data read request.
- `dWEN` in CPUS: data write request.
- `daddr` in CPUS×ADDR_W: data address.
- `dstore` in CPUS×WORD_W: write data.
- `iwait` out CPUS: 0 = instruction access completes this cycle.
- `iload` out CPUS×WORD_W: instruction read data.
- `dwait` out CPUS: 0 = data access completes this cycle.
- `dload` out CPUS×WORD_W: data read data.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out ADDR_W: RAM address.
- `ramstore` out WORD_W: RAM write data.
- `ramload` in WORD_W: RAM read data.
- `ramstate` in 2: RAM state, encoded FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- **State**: FSM {IDLE, GRANT}. Grant registers:
  - `g_idx` (clog2(CPUS) bits);
  - `g_data` (1 = data, 0 = instruction).
- **Pointers and counter**:
  - `i_ptr` and `d_ptr`, round-robin, reset 0.
  - `starve_cnt`, saturating at `STARVE_LIMIT`, reset 0.
- **IDLE arbitration**, evaluated each cycle; the result is registered at the edge and the FSM goes to GRANT:
  - If `starve_cnt == STARVE_LIMIT` and any `iREN` is set: instruction winner.
  - Else if any `dREN|dWEN` is set: data winner, first set index searching from `d_ptr` upward with wrap.
  - Else if any `iREN` is set: instruction winner, first set index searching from `i_ptr` with wrap.
  - Else: stay in IDLE.
- **GRANT, data grant** to CPU k:
  - `ramaddr = daddr[k]`.
  - If `dWEN[k]`: `ramWEN = 1`, `ramREN = 0`, `ramstore = dstore[k]`. Write wins when `dREN[k]` and `dWEN[k]` are both set.
  - Otherwise: `ramREN = 1`.
  - `dload[k] = ramload`.
  - `dwait[k] = (ramstate != ACCESS)`.
- **GRANT, instruction grant** to CPU k:
  - `ramaddr = iaddr[k]`, `ramREN = 1`, `iload[k] = ramload`.
  - `iwait[k] = (ramstate != ACCESS)`.
- **Non-granted ports**: `iwait`/`dwait` = 1; `iload`/`dload` = 0.
- **Completion** (`ramstate == ACCESS` in GRANT):
  - Next edge → IDLE.
  - The pointer of the granted class becomes `(k+1) mod CPUS`.
  - Data grant: `starve_cnt` increments (saturating) if any `iREN` was set that cycle, otherwise clears.
  - Instruction grant: `starve_cnt` clears.
- **Abort**: in GRANT, if the granted request bit(s) drop (`iREN[k]`; or both `dREN[k]` and `dWEN[k]`), then that same cycle RAM enables = 0 and waits stay 1. Next edge → IDLE. Pointers and counter are unchanged.
- **ERROR or BUSY/FREE `ramstate`**: treated as not-ready; the grant is held indefinitely, with no timeout.
- **IDLE outputs**: all waits 1, loads 0, RAM enables 0, `ramaddr`/`ramstore` 0.

## Timing
- **Reset** (asynchronous, immediate):
  - FSM = IDLE, pointers = 0, `starve_cnt` = 0.
  - `iwait` and `dwait` = all 1; `iload`, `dload`, `ramaddr`, `ramstore` = 0; `ramREN` and `ramWEN` = 0.
  - Reset asserted mid-GRANT drops RAM enables in the same cycle, without waiting for the clock.
- **Latency**: request at cycle 0 → RAM driven from cycle 1 → wait low in the first GRANT cycle with ACCESS. With a 1-cycle RAM (ACCESS in cycle 1), completion is in cycle 1.
- **Bubble**: one IDLE cycle between consecutive grants; steady-state ≥2 cycles per transaction.
- **Output style**: all RAM outputs, waits and loads are combinational from the grant registers plus `ramstate`/`ramload`. No input-to-output combinational path exists through the arbitration search.
- **Request stability**: requests and addresses must stay stable while granted; changing the address mid-grant is undefined except for the abort rule above.

## Test plan
- **Reset**: reset asserted mid-grant.
  - Required: `ramREN` = `ramWEN` = 0 and all waits = 1 immediately.
  - After release, with `iREN[0]` set, the first grant is instruction to CPU 0.
- **Single instruction fetch**: CPUS=2, `iREN=2'b01`, `iaddr[0]=0x40`, RAM ACCESS in cycle 1 with `ramload=0xDEADBEEF`.
  - Required in cycle 1: `ramaddr=0x40`, `ramREN=1`, `iwait[0]=0`, `iload[0]=0xDEADBEEF`.
  - Required afterwards: `i_ptr=1`.
- **Round-robin**: both `iREN` held continuously.
  - Required: grants alternate CPU 0, 1, 0, 1, with each grant completing 2 cycles after the previous one.
- **Data priority and write precedence**: `iREN[0]`, `dREN[1]` and `dWEN[1]` all set, `dstore[1]=0x1234`, `daddr[1]=0x80`.
  - Required: data grant to CPU 1 first, with `ramWEN=1`, `ramREN=0`, `ramaddr=0x80`, `ramstore=0x1234`.
- **Starvation guard**: STARVE_LIMIT=4, `dREN[0]` held continuously, `iREN[1]` held continuously.
  - Required: 4 data completions, then an instruction grant to CPU 1, then data resumes.
- **Abort**: data grant to CPU 0 with `ramstate=BUSY` for 3 cycles, then `dREN[0]` drops.
  - Required: RAM enables drop that cycle, FSM → IDLE, `d_ptr` still 0.
